// File: rtl/ps2_key_pkg.sv
// Shared constants, state type and key-map function for the PS/2 key decoder.
package ps2_key_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    localparam logic [2:0] KEY_NONE      = 3'd0;
    localparam logic [2:0] KEY_NEW_GAME  = 3'd1;
    localparam logic [2:0] KEY_HARD_DROP = 3'd2;
    localparam logic [2:0] KEY_ROT_CW    = 3'd3;
    localparam logic [2:0] KEY_ROT_CCW   = 3'd4;
    localparam logic [2:0] KEY_LEFT      = 3'd5;
    localparam logic [2:0] KEY_RIGHT     = 3'd6;
    localparam logic [2:0] KEY_SOFT_DROP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK
    } frame_state_t;

    // KEY_NONE doubles as "unmapped": no game key is ever encoded as 0.
    function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
        case ({ext, code})
            {1'b0, SC_ENTER}: return KEY_NEW_GAME;
            {1'b0, SC_SPACE}: return KEY_HARD_DROP;
            {1'b1, SC_UP}:    return KEY_ROT_CW;
            {1'b0, SC_Z}:     return KEY_ROT_CCW;
            {1'b1, SC_LEFT}:  return KEY_LEFT;
            {1'b1, SC_RIGHT}: return KEY_RIGHT;
            {1'b1, SC_DOWN}:  return KEY_SOFT_DROP;
            default:          return KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM,
// inter-edge timeout and parity/stop check. Strobes are valid for one cycle.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       rx_err
);
    import ps2_key_pkg::*;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filter_done, sample_pt;

    frame_state_t  state, state_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [9:0]    shreg, shreg_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;

    // The filtered level flips on the cycle the FILTER_LEN-th differing sample arrives.
    assign filter_done = (clk_sync != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample_pt   = filter_done && filt_clk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_meta <= PS2_clk;
            clk_sync <= clk_meta;
            dat_meta <= PS2_data;
            dat_sync <= dat_meta;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filter_done) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        tmo_nxt     = tmo_cnt;
        rx_stb      = 1'b0;
        rx_err      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_pt && !dat_sync) begin
                    state_nxt   = ST_RX;
                    bit_cnt_nxt = '0;
                    tmo_nxt     = '0;
                end
            end
            ST_RX: begin
                if (sample_pt) begin
                    shreg_nxt = {dat_sync, shreg[9:1]};
                    tmo_nxt   = '0;
                    if (bit_cnt == 4'd9) state_nxt = ST_CHECK;
                    else                 bit_cnt_nxt = bit_cnt + 1'b1;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    rx_err    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                // shreg = {stop, parity, data[7:0]} once all ten bits are in.
                if ((^shreg[8:0]) && shreg[9]) rx_stb = 1'b1;
                else                           rx_err = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rx_byte = shreg[7:0];

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 make/break decoder: tracks E0/F0 prefixes and holds the current game key,
// registered in the same cycle as byte_stb.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [2:0] key,
    output logic [7:0] scan_byte,
    output logic       byte_stb,
    output logic       frame_err
);
    import ps2_key_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_stb, rx_err;
    logic       ext, brk;
    logic [2:0] code;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .PS2_clk  (PS2_clk),
        .PS2_data (PS2_data),
        .rx_byte  (rx_byte),
        .rx_stb   (rx_stb),
        .rx_err   (rx_err)
    );

    assign code = map_key(ext, rx_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key       <= KEY_NONE;
            scan_byte <= 8'h00;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            byte_stb  <= rx_stb;
            frame_err <= rx_err;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_stb) begin
                scan_byte <= rx_byte;
                if (rx_byte == SC_E0) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_F0) begin
                    brk <= 1'b1;
                end else begin
                    // A break only releases the key it names; a stale break is ignored.
                    if (code != KEY_NONE) begin
                        if (!brk)             key <= code;
                        else if (code == key) key <= KEY_NONE;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_key_decoder;

    localparam int N    = 8;
    localparam int T    = 20000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       PS2_clk;
    logic       PS2_data;
    logic [2:0] key;
    logic [7:0] scan_byte;
    logic       byte_stb;
    logic       frame_err;

    int cyc = 0;
    int stb_cnt = 0, err_cnt = 0, overlap = 0;
    int last_stb_cyc = -1, last_err_cyc = -1;
    int fall_cyc = 0;
    int n_checks = 0, n_pass = 0;
    int s0, e0, f0;

    ps2_key_decoder #(.FILTER_LEN(N), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PS2_clk   (PS2_clk),
        .PS2_data  (PS2_data),
        .key       (key),
        .scan_byte (scan_byte),
        .byte_stb  (byte_stb),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_stb) begin
            stb_cnt++;
            last_stb_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (byte_stb && frame_err) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Frame bit i goes on the wire i-th: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [7:0] b, input logic bad_par,
                             input int first, input int last, input int glitch_bit);
        logic [10:0] f;
        f = frame_bits(b, bad_par);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            PS2_data = f[i];
            if (i == glitch_bit) begin
                repeat (6) @(negedge clk);
                PS2_clk = 1'b0;
                repeat (3) @(negedge clk);
                PS2_clk = 1'b1;
                repeat (HALF - 9) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            PS2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            PS2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input int glitch_bit);
        send_bits(b, bad_par, 0, 10, glitch_bit);
        repeat (3 * HALF) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        PS2_clk  = 1'b1;
        PS2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key", key, 3'd0);
        check("rst_scan", scan_byte, 8'h00);
        check("rst_stb", byte_stb, 1'b0);
        check("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Space make, with strobe latency measured from the stop-bit falling edge
        send_byte(8'h29, 1'b0, -1);
        check("space_stb_cnt", stb_cnt, 1);
        check("space_scan", scan_byte, 8'h29);
        check("space_key", key, 3'd2);
        check("stb_latency", last_stb_cyc, fall_cyc + N + 3);

        send_byte(8'hF0, 1'b0, -1);
        check("f0_key_held", key, 3'd2);
        send_byte(8'h29, 1'b0, -1);
        check("space_break", key, 3'd0);

        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'h6B, 1'b0, -1);
        check("left_make", key, 3'd5);
        send_byte(8'h1A, 1'b0, -1);
        check("z_make", key, 3'd4);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h6B, 1'b0, -1);
        check("stale_break", key, 3'd4);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h1A, 1'b0, -1);
        check("z_break", key, 3'd0);
        check("scan_1a", scan_byte, 8'h1A);

        // Bad parity
        s0 = stb_cnt;
        e0 = err_cnt;
        send_byte(8'h5A, 1'b1, -1);
        check("par_err_cnt", err_cnt, e0 + 1);
        check("par_no_stb", stb_cnt, s0);
        check("par_key", key, 3'd0);
        check("par_scan", scan_byte, 8'h1A);

        // Partial frame: start + 4 data bits, then silence
        e0 = err_cnt;
        send_bits(8'h29, 1'b0, 0, 4, -1);
        f0 = fall_cyc;
        repeat (T + N + 50) @(negedge clk);
        check("tmo_err_cnt", err_cnt, e0 + 1);
        check("tmo_err_cycle", last_err_cyc, f0 + N + 2 + T);
        send_byte(8'h29, 1'b0, -1);
        check("after_tmo_key", key, 3'd2);

        // Glitches on PS2_clk in idle and inside a frame
        s0 = stb_cnt;
        e0 = err_cnt;
        @(negedge clk);
        PS2_clk = 1'b0;
        repeat (3) @(negedge clk);
        PS2_clk = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        send_byte(8'h5A, 1'b0, 4);
        check("glitch_stb_cnt", stb_cnt, s0 + 1);
        check("glitch_err_cnt", err_cnt, e0);
        check("glitch_scan", scan_byte, 8'h5A);
        check("glitch_key", key, 3'd1);

        // Reset after the 6th data bit
        send_bits(8'h5A, 1'b0, 0, 6, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_key", key, 3'd0);
        check("midrst_scan", scan_byte, 8'h00);
        check("midrst_stb", byte_stb, 1'b0);
        check("midrst_err", frame_err, 1'b0);
        s0 = stb_cnt;
        send_bits(8'h5A, 1'b0, 7, 10, -1);
        repeat (T + N + 100) @(negedge clk);
        check("midrst_no_stb", stb_cnt, s0);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        check("up_make", key, 3'd3);
        check("up_scan", scan_byte, 8'h75);

        check("stb_err_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
